// File: rtl/key_fifo_bridge.sv
// key_fifo_bridge: buffers decoder keystrokes in a pop-on-read FIFO for the
// CPU bus and raises the keyboard interrupt vector until acknowledged.
// Optional build macro: KEY_FIFO_OVERWRITE_EN (push into a full FIFO replaces
// the oldest entry instead of being dropped).
module key_fifo_bridge #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [3:0]  IRQ_VECTOR = 4'd1
) (
  input  logic                     CLOCK_50,
  input  logic                     KEY0,
  input  logic                     key_pressed,
  input  logic [7:0]               ascii,
  input  logic                     rd_req,
  output logic [63:0]              rd_data,
  output logic                     rd_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [3:0]               interrupt_vector,
  input  logic                     interrupt_ack
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

`ifdef KEY_FIFO_OVERWRITE_EN
  localparam logic OVERWRITE = 1'b1;
`else
  localparam logic OVERWRITE = 1'b0;
`endif

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          key_pressed_q;
  logic [63:0]   rd_data_q, rd_data_d;
  logic          rd_done_q;
  logic          ovf_q, ovf_d;
  logic          armed_q, armed_d;
  logic [3:0]    irq_q;

  logic push_c, empty_c, full_c, pop_c, wr_c, rp_adv_c, ovf_set_c;

  // Event decode and next-state for pointers, occupancy, flags and read data
  always_comb begin
    push_c    = key_pressed & ~key_pressed_q & (ascii != 8'd0);
    empty_c   = (count_q == '0);
    full_c    = (count_q == CW'(DEPTH));
    pop_c     = rd_req & ~empty_c;
    // A full FIFO accepts the push only when a pop frees the slot, or when overwriting
    wr_c      = push_c & (~full_c | pop_c | OVERWRITE);
    rp_adv_c  = pop_c | (wr_c & full_c);
    ovf_set_c = push_c & full_c & ~rd_req;

    wp_d      = wr_c     ? wp_q + AW'(1) : wp_q;
    rp_d      = rp_adv_c ? rp_q + AW'(1) : rp_q;

    count_d   = count_q;
    if (wr_c && !full_c && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_c && !wr_c) begin
      count_d = count_q - CW'(1);
    end

    rd_data_d = rd_data_q;
    if (rd_req) begin
      rd_data_d = pop_c ? {56'd0, mem[rp_q]} : 64'd0;
    end

    ovf_d = ovf_q;
    if (ovf_set_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    armed_d = armed_q;
    if (push_c) begin
      armed_d = 1'b1;
    end else if (interrupt_ack && armed_q) begin
      armed_d = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      key_pressed_q <= 1'b0;
      rd_data_q     <= 64'd0;
      rd_done_q     <= 1'b0;
      ovf_q         <= 1'b0;
      armed_q       <= 1'b0;
      irq_q         <= 4'd0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      key_pressed_q <= key_pressed;
      rd_data_q     <= rd_data_d;
      rd_done_q     <= rd_req;
      ovf_q         <= ovf_d;
      armed_q       <= armed_d;
      irq_q         <= armed_q ? IRQ_VECTOR : 4'd0;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge CLOCK_50) begin
    if (wr_c) begin
      mem[wp_q] <= ascii;
    end
  end

  assign rd_data          = rd_data_q;
  assign rd_done          = rd_done_q;
  assign count            = count_q;
  assign overflow         = ovf_q;
  assign interrupt_vector = irq_q;

endmodule

// File: doc/key_fifo_bridge.md
# key_fifo_bridge

Buffers ASCII keystrokes from the PS/2 decoder and serves them to the CPU bus as a registered, pop-on-read FIFO. It also raises the keyboard interrupt vector until the CPU acknowledges it. It sits between `ps2_decoder` (upstream) and the bus read mux / interrupt inputs of `riscv64` (downstream). It replaces the single live-`ascii` register read at `Key_base`, so keystrokes are no longer lost between CPU reads.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `IRQ_VECTOR`, 4'd1: value driven on `interrupt_vector` while the interrupt is raised.

Ports:
- `CLOCK_50`, in, 1: the single clock, 50 MHz.
- `KEY0`, in, 1: reset, asynchronous, active-low.
- `key_pressed`, in, 1: level from the decoder; high while a make code is held.
- `ascii`, in, 8: ASCII code from the decoder; valid while `key_pressed` is high.
- `rd_req`, in, 1: one-cycle pop request from the bus decode (`Key_selected` read).
- `rd_data`, out, 64: `{56'd0, byte}`.
- `rd_done`, out, 1: one-cycle pulse; `rd_data` is valid in the same cycle.
- `count`, out, log2(DEPTH)+1: current occupancy.
- `overflow`, out, 1: sticky flag; set when a keystroke is lost or overwritten.
- `clr_ovf`, in, 1: one-cycle pulse that clears `overflow`.
- `interrupt_vector`, out, 4: `IRQ_VECTOR` when raised, otherwise 0.
- `interrupt_ack`, in, 1: CPU acknowledge.

## Operation

- **Push detection:** `push = key_pressed & ~key_pressed_q & (ascii != 0)`. `key_pressed_q` is registered. Holding a key produces exactly one push. A zero `ascii` is never pushed.
- **Storage:** circular buffer with write pointer `wp`, read pointer `rp` and `count`. Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. `count` ranges 0..DEPTH.
- **Pop:** on `rd_req`:
  - Not empty: `rd_data <= {56'd0, mem[rp]}`, `rp++`, `count--`.
  - Empty: `rd_data <= 64'd0`, no pointer change.
  - `rd_done` pulses in both cases.
- **Simultaneous push and pop:**
  - Non-empty FIFO: both occur and `count` is unchanged.
  - Empty FIFO: the pop returns 0 (no bypass) and the push is stored.
  - Full FIFO: both occur and no overflow is flagged.
- **Push when full without pop:** see Configuration. `overflow <= 1` in either build.
- **Overflow clear:** `clr_ovf` clears `overflow`. A set in the same cycle wins over the clear.
- **Interrupt:**
  - Register `armed`. A push sets `armed`. `interrupt_ack & armed` clears it.
  - If push and ack occur in the same cycle, push wins.
  - `interrupt_vector <= armed ? IRQ_VECTOR : 0`, registered.
  - Draining the FIFO does not clear `armed`; only ack does.
- **Reset** (asynchronous on `KEY0` low): all of the following go to 0:
  - `wp`, `rp`, `count`, `key_pressed_q`
  - `rd_data`, `rd_done`, `overflow`
  - `armed`, `interrupt_vector`

  FIFO memory contents are not reset. A reset mid-read drops any pending `rd_done`.

## Timing

- `key_pressed` rises in cycle N: the byte is written at the end of N. `count` increments and `armed` sets at the same edge. `interrupt_vector` reads `IRQ_VECTOR` from cycle N+2.
- `rd_req` high in cycle N: `rd_data` and `rd_done` are valid in N+1, so read latency is 1 cycle. `rd_done` is high for exactly one cycle.
- A back-to-back `rd_req` on every cycle pops one entry per cycle.
- `interrupt_ack` high in cycle N: `armed` clears at the end of N and `interrupt_vector` reads 0 from N+2.
- `count` is registered and reflects a push or pop one cycle after it.

## Configuration

Macro `KEY_FIFO_OVERWRITE_EN`:
- **Defined:** a push into a full FIFO without a pop overwrites the oldest entry. `mem[wp] <= ascii`, `wp++`, `rp++`, `count` stays DEPTH.
- **Undefined (default):** a push into a full FIFO without a pop is dropped. Pointers and `count` are unchanged.
- `overflow` sets in both builds.

## Test plan

- **Reset values:** hold `KEY0` low mid-stream, then release. All outputs are 0, and `rd_req` returns `rd_data=0` with `rd_done=1`.
- **Order and interrupt:** push 'a'(0x61), 'b'(0x62) with `key_pressed` held 5 cycles each. `count=2`, `interrupt_vector=1`. Two `rd_req` return 0x61 then 0x62, each with a 1-cycle `rd_done`, and `count=0`.
- **Ack and re-arm:** with one entry queued, pulse `interrupt_ack`. Vector reads 0 two cycles later while `count` stays 1. A new push re-raises the vector.
- **Overflow, default build:** DEPTH=16, push 17 keys 0x41..0x51. `count=16`, `overflow=1`, and reads return 0x41..0x50. `clr_ovf` clears the flag.
- **Overflow, `KEY_FIFO_OVERWRITE_EN` build:** same stimulus. Reads return 0x42..0x51 and `overflow=1`.
- **Full FIFO push and pop:** with the FIFO full, push and `rd_req` in the same cycle. `count` stays 16, `overflow` stays 0, and the oldest byte is returned. Separately, `ascii=0` with `key_pressed` causes no push.
